// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a small FIFO absorbs producer bursts, and a
// bit-timing FSM serialises each word as start, data (LSB first), optional
// parity and stop bit(s). Consecutive frames are sent with no idle gap.
module uart_tx_buffered #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int WIDTH      = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [WIDTH-1:0]              data_in,
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  output logic                          serial_out,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W  = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int OCC_W  = PTR_W + 1;
  localparam int IDX_W  = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(SYMBOL_EDGE_TIME - 1);
  localparam logic [IDX_W-1:0] DATA_LAST     = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] STOP_LAST     = IDX_W'(STOP_BITS - 1);
  localparam logic [OCC_W-1:0] FULL_COUNT    = OCC_W'(FIFO_DEPTH);
  localparam logic             PARITY_INVERT = (PARITY == 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
  } state_e;

  // FIFO storage and bookkeeping
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic             push, pop, empty, full;
  logic [WIDTH-1:0] head;

  // Transmit FSM state
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             serial_q, serial_d;
  logic             busy_q, busy_d;
  logic             bit_done;

  // Ready is a function of the registered occupancy only, so a pop in the
  // same cycle cannot open a full FIFO.
  assign full          = (count_q == FULL_COUNT);
  assign empty         = (count_q == '0);
  assign data_in_ready = !full;
  assign push          = data_in_valid && !full;
  assign head          = mem_q[rd_ptr_q];
  assign bit_done      = (cnt_q == CNT_LAST);

  assign serial_out = serial_q;
  assign tx_busy    = busy_q;
  assign fifo_count = count_q;

  // FIFO pointer and occupancy next-state; pointers wrap naturally at FIFO_DEPTH.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO registers and storage.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      // NOTE: storage is cleared too so every register has a known value after reset.
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= data_in;
    end
  end

  // Frame sequencing: bit timing, state transitions, next line level and pop.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    serial_d = serial_q;
    pop      = 1'b0;

    if (state_q != ST_IDLE) cnt_d = bit_done ? '0 : cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        serial_d = 1'b1;
        cnt_d    = '0;
        if (!empty) pop = 1'b1;
      end
      ST_START: begin
        if (bit_done) begin
          state_d  = ST_DATA;
          idx_d    = '0;
          serial_d = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (idx_q == DATA_LAST) begin
            idx_d = '0;
            if (PARITY != 0) begin
              state_d  = ST_PARITY;
              serial_d = parity_q;
            end else begin
              state_d  = ST_STOP;
              serial_d = 1'b1;
            end
          end else begin
            idx_d    = idx_q + 1'b1;
            shift_d  = shift_q >> 1;
            serial_d = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          state_d  = ST_STOP;
          idx_d    = '0;
          serial_d = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          if (idx_q == STOP_LAST) begin
            if (!empty) begin
              pop = 1'b1;
            end else begin
              state_d  = ST_IDLE;
              serial_d = 1'b1;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        serial_d = 1'b1;
      end
    endcase

    // A pop always launches a new frame from the latched head word.
    if (pop) begin
      state_d  = ST_START;
      idx_d    = '0;
      shift_d  = head;
      parity_d = (^head) ^ PARITY_INVERT;
      serial_d = 1'b0;
    end
  end

  assign busy_d = (state_d != ST_IDLE);

  // FSM registers, including the registered line and busy outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered. Five builds share clock, reset
// and data bus; accepted words go into a scoreboard queue and are compared
// cycle-by-cycle against the serial line when their frame appears.
module tb_uart_tx_buffered;

  localparam int BIT_T = 10;  // 1000 Hz / 100 baud

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] din;
  logic [4:0] valid;
  logic [4:0] rdy;
  logic [4:0] ser;
  logic [4:0] busy;
  logic [2:0] cnt0;
  logic [3:0] cnt1, cnt2, cnt3, cnt4;

  int vectors     = 0;
  int miscompares = 0;
  logic [8:0] exp_q [$];

  int cfg_width [5] = '{8, 8, 8, 5, 9};
  int cfg_par   [5] = '{0, 1, 2, 0, 0};
  int cfg_stop  [5] = '{1, 2, 2, 1, 1};

  always #5 clk = ~clk;

  uart_tx_buffered #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .WIDTH(8), .PARITY(0),
                     .STOP_BITS(1), .FIFO_DEPTH(4)) u_base (
    .clk(clk), .reset(reset), .data_in(din[7:0]), .data_in_valid(valid[0]),
    .data_in_ready(rdy[0]), .serial_out(ser[0]), .tx_busy(busy[0]), .fifo_count(cnt0));

  uart_tx_buffered #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .WIDTH(8), .PARITY(1),
                     .STOP_BITS(2), .FIFO_DEPTH(8)) u_odd (
    .clk(clk), .reset(reset), .data_in(din[7:0]), .data_in_valid(valid[1]),
    .data_in_ready(rdy[1]), .serial_out(ser[1]), .tx_busy(busy[1]), .fifo_count(cnt1));

  uart_tx_buffered #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .WIDTH(8), .PARITY(2),
                     .STOP_BITS(2), .FIFO_DEPTH(8)) u_even (
    .clk(clk), .reset(reset), .data_in(din[7:0]), .data_in_valid(valid[2]),
    .data_in_ready(rdy[2]), .serial_out(ser[2]), .tx_busy(busy[2]), .fifo_count(cnt2));

  uart_tx_buffered #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .WIDTH(5), .PARITY(0),
                     .STOP_BITS(1), .FIFO_DEPTH(8)) u_w5 (
    .clk(clk), .reset(reset), .data_in(din[4:0]), .data_in_valid(valid[3]),
    .data_in_ready(rdy[3]), .serial_out(ser[3]), .tx_busy(busy[3]), .fifo_count(cnt3));

  uart_tx_buffered #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .WIDTH(9), .PARITY(0),
                     .STOP_BITS(1), .FIFO_DEPTH(8)) u_w9 (
    .clk(clk), .reset(reset), .data_in(din), .data_in_valid(valid[4]),
    .data_in_ready(rdy[4]), .serial_out(ser[4]), .tx_busy(busy[4]), .fifo_count(cnt4));

  // Offer a word to one build; on acceptance push it to the scoreboard and
  // scramble the data bus so later frames cannot depend on it.
  task automatic push(input int inst, input logic [8:0] w, input int max_wait,
                      output bit accepted, output int rejected);
    logic [8:0] mask;
    accepted = 1'b0;
    rejected = 0;
    mask = 9'((1 << cfg_width[inst]) - 1);
    @(negedge clk);
    din         = w;
    valid[inst] = 1'b1;
    while (!accepted && rejected < max_wait) begin
      if (rdy[inst] === 1'b1) begin
        @(posedge clk);
        accepted = 1'b1;
        exp_q.push_back(w & mask);
      end else begin
        @(posedge clk);
        rejected++;
        @(negedge clk);
      end
    end
    #1;
    valid[inst] = 1'b0;
    din         = 9'($urandom);
  endtask

  // Scoreboard consumer: find the start bit (timeout 0 = already on its first
  // cycle), then check every cycle of every bit against the expected word.
  task automatic check_frame(input int inst, input int timeout, input bit idle_after,
                             input string name);
    int width, par, stop, nb;
    bit found, bad;
    logic [8:0] w;
    logic exp_b, par_b, seen_l, seen_b;
    width = cfg_width[inst];
    par   = cfg_par[inst];
    stop  = cfg_stop[inst];
    nb    = 1 + width + ((par != 0) ? 1 : 0) + stop;
    found = (timeout == 0);
    for (int c = 0; c < timeout && !found; c++) begin
      @(negedge clk);
      if (ser[inst] === 1'b0) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL %s_start: line stayed %b, start bit required within %0d cycles",
               name, ser[inst], timeout);
      return;
    end
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s_scoreboard: frame seen, no word expected", name);
      return;
    end
    w = exp_q.pop_front();
    par_b = (par == 1);
    for (int i = 0; i < width; i++) par_b = par_b ^ w[i];
    for (int b = 0; b < nb; b++) begin
      if (b == 0)                          exp_b = 1'b0;
      else if (b <= width)                 exp_b = w[b-1];
      else if (par != 0 && b == width + 1) exp_b = par_b;
      else                                 exp_b = 1'b1;
      bad    = 1'b0;
      seen_l = exp_b;
      seen_b = 1'b1;
      for (int cy = 0; cy < BIT_T; cy++) begin
        if (b != 0 || cy != 0) @(negedge clk);
        if (ser[inst] !== exp_b || busy[inst] !== 1'b1) begin
          bad    = 1'b1;
          seen_l = ser[inst];
          seen_b = busy[inst];
        end
      end
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL %s_bit%0d: word %h got line=%b busy=%b, expected line=%b busy=1",
                 name, b, w, seen_l, seen_b, exp_b);
      end
    end
    if (idle_after) begin
      @(negedge clk);
      vectors++;
      if ({ser[inst], busy[inst]} !== 2'b10) begin
        miscompares++;
        $display("FAIL %s_idle: got line=%b busy=%b, expected line=1 busy=0",
                 name, ser[inst], busy[inst]);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    valid = '0;
    din   = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({ser, busy, rdy, cnt0} !== {5'b11111, 5'b00000, 5'b11111, 3'd0}) begin
      miscompares++;
      $display("FAIL reset_values: ser=%b busy=%b rdy=%b count=%0d, expected 11111 00000 11111 0",
               ser, busy, rdy, cnt0);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({ser, busy, rdy, cnt0} !== {5'b11111, 5'b00000, 5'b11111, 3'd0}) begin
      miscompares++;
      $display("FAIL reset_release: ser=%b busy=%b rdy=%b count=%0d, expected 11111 00000 11111 0",
               ser, busy, rdy, cnt0);
    end
  endtask

  task automatic test_single;
    bit acc;
    int rej;
    push(0, 9'h0A5, 5, acc, rej);
    vectors++;
    if (!acc) begin
      miscompares++;
      $display("FAIL single_accept: word not accepted, expected immediate accept");
    end
    @(negedge clk);  // after push edge N
    vectors++;
    if ({ser[0], busy[0], cnt0} !== {1'b1, 1'b0, 3'd1}) begin
      miscompares++;
      $display("FAIL single_edge_n: line=%b busy=%b count=%0d, expected 1 0 1",
               ser[0], busy[0], cnt0);
    end
    @(negedge clk);  // after edge N+1
    vectors++;
    if ({ser[0], busy[0], cnt0} !== {1'b0, 1'b1, 3'd0}) begin
      miscompares++;
      $display("FAIL single_edge_n1: line=%b busy=%b count=%0d, expected 0 1 0",
               ser[0], busy[0], cnt0);
    end
    check_frame(0, 0, 1'b1, "single");
  endtask

  task automatic test_parity;
    bit acc;
    int rej;
    push(1, 9'h003, 5, acc, rej);
    check_frame(1, 20, 1'b1, "odd_parity");
    push(2, 9'h003, 5, acc, rej);
    check_frame(2, 20, 1'b1, "even_parity");
  endtask

  task automatic test_back_to_back;
    logic [8:0] words [5] = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055};
    fork
      begin
        bit acc;
        int rej;
        for (int k = 0; k < 5; k++) begin
          push(0, words[k], 1, acc, rej);
          vectors++;
          if (!acc) begin
            miscompares++;
            $display("FAIL burst_accept%0d: word %h refused, expected accept", k, words[k]);
          end
        end
        vectors++;
        if ({rdy[0], cnt0} !== {1'b0, 3'd4}) begin
          miscompares++;
          $display("FAIL burst_full: ready=%b count=%0d, expected 0 4", rdy[0], cnt0);
        end
        push(0, 9'h066, 200, acc, rej);
        vectors++;
        if (!acc || rej != 97) begin
          miscompares++;
          $display("FAIL full_hold: accepted=%b after %0d refused edges, expected 1 after 97",
                   acc, rej);
        end
      end
      begin
        check_frame(0, 20, 1'b0, "burst_f0");
        for (int k = 1; k < 6; k++) check_frame(0, 1, (k == 5), $sformatf("burst_f%0d", k));
      end
    join
  endtask

  task automatic test_reset_mid_frame;
    bit acc, bad;
    int rej;
    push(0, 9'h0C3, 5, acc, rej);
    push(0, 9'h03C, 5, acc, rej);
    push(0, 9'h099, 5, acc, rej);
    repeat (33) @(negedge clk);
    vectors++;
    if ({busy[0], cnt0} !== {1'b1, 3'd2}) begin
      miscompares++;
      $display("FAIL midreset_pre: busy=%b count=%0d, expected 1 2", busy[0], cnt0);
    end
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    vectors++;
    if ({ser[0], busy[0], cnt0, rdy[0]} !== {1'b1, 1'b0, 3'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL midreset_post: line=%b busy=%b count=%0d ready=%b, expected 1 0 0 1",
               ser[0], busy[0], cnt0, rdy[0]);
    end
    reset = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (ser[0] !== 1'b1 || busy[0] !== 1'b0 || cnt0 !== 3'd0) bad = 1'b1;
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL midreset_quiet: activity after reset, expected idle line and empty FIFO");
    end
    push(0, 9'h05A, 5, acc, rej);
    check_frame(0, 20, 1'b1, "after_reset");
  endtask

  task automatic test_widths;
    bit acc;
    int rej;
    push(3, 9'h015, 5, acc, rej);
    check_frame(3, 20, 1'b1, "width5");
    push(4, 9'h1AB, 5, acc, rej);
    check_frame(4, 20, 1'b1, "width9");
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_widths();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
Parametrised UART transmitter with an input FIFO and a configurable frame format: data width, parity mode and stop-bit count. Sits between on-chip producers (for example a ready/valid stream from the FPGA fabric) and the board's serial TX pin. Accepts bursts of words without stalling the producer for a whole frame time, then serialises them back-to-back. Each frame is start bit, data LSB first, optional parity, then stop bit(s).

Parameters:
CLOCK_FREQ, 100_000_000, clk frequency in Hz
BAUD_RATE, 115_200, line rate in bit/s; SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE clk cycles per bit (integer division)
WIDTH, 8, data bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits, legal 1 or 2
FIFO_DEPTH, 8, input FIFO entries, power of 2, >= 2

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
data_in  input  WIDTH  word to transmit
data_in_valid  input  1  producer has a word on data_in
data_in_ready  output  1  FIFO can accept a word; equals !full
serial_out  output  1  UART TX line, idle high, registered
tx_busy  output  1  high while a frame is on the line
fifo_count  output  $clog2(FIFO_DEPTH)+1  words currently buffered, excluding the frame in flight

Behaviour:
- Reset is synchronous, active-high, clock clk. It applies to every register.
  - Values after reset: serial_out=1, tx_busy=0, fifo_count=0, data_in_ready=1, state IDLE, all counters 0.
  - Reset mid-frame aborts the frame: serial_out=1 at the next edge and buffered words are discarded.
- Push handshake: a word is accepted on a rising edge where data_in_valid && data_in_ready.
  - data_in_ready depends only on FIFO occupancy; there is no combinational path from data_in_valid or from the pop.
  - When full, data_in_ready=0 even if a pop happens in the same cycle.
  - data_in_valid while ready=0 is ignored; the producer holds the word.
- Pop: occurs in the cycle where the FSM is in IDLE, or finishing the last stop-bit cycle, and the FIFO is non-empty.
  - The popped word is latched into the shift register.
  - Parity is computed from the latched word: even = XOR of the data bits; odd = inverted XOR.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when the FIFO is non-empty.
  - START -> DATA after SYMBOL_EDGE_TIME cycles.
  - DATA: WIDTH bits, LSB first, SYMBOL_EDGE_TIME cycles each. Exits to PARITY if PARITY != 0, otherwise to STOP.
  - PARITY: one bit time.
  - STOP: STOP_BITS * SYMBOL_EDGE_TIME cycles at 1. Exits to START if the FIFO is non-empty (zero idle gap between frames), otherwise to IDLE.
- Bit timing:
  - One cycle counter runs 0..SYMBOL_EDGE_TIME-1.
  - The bit index advances, and the counter wraps to 0, when the counter reaches SYMBOL_EDGE_TIME-1.
  - Every bit is exactly SYMBOL_EDGE_TIME cycles. Frame length = (1 + WIDTH + (PARITY!=0) + STOP_BITS) * SYMBOL_EDGE_TIME cycles.
- Latency: a word pushed at edge N into an empty FIFO with the FSM in IDLE gives serial_out=0 from edge N+1 (start bit).
  - fifo_count reads 1 after edge N and 0 after edge N+1.
- tx_busy is 1 for exactly the cycles in which the FSM is not IDLE. serial_out is 1 in IDLE.
- Simultaneous push and pop: count is unchanged, and pointers wrap modulo FIFO_DEPTH.
- Words are transmitted in acceptance order, with no loss and no duplication.
- Changes on data_in while the FSM is mid-frame never affect the frame in flight.

Test Plan:
- Single frame, CLOCK_FREQ=1000, BAUD_RATE=100 (10 cycles/bit), WIDTH=8, PARITY=0, STOP_BITS=1; push 0xA5 -> serial_out low at the next edge. Sampling mid-bit gives 0,1,0,1,0,0,1,0,1,1. tx_busy is high for exactly 100 cycles, then the line idles at 1.
- Parity and stop bits, PARITY=1 (odd), STOP_BITS=2; push 0x03 -> parity bit is 1 and there are 20 stop cycles (frame 120 cycles). With PARITY=2 (even), 0x03 gives parity bit 0.
- Burst/back-to-back, FIFO_DEPTH=4; push 0x11,0x22,0x33,0x44,0x55 on consecutive cycles -> data_in_ready drops after 5 accepts. This is 1 word loaded plus 4 buffered. The five frames appear contiguously with no idle cycle between the stop bit and the next start bit, in order.
- Full boundary: with the FIFO full, hold data_in_valid=1 with 0x66 -> not accepted until the first pop. Then accepted, and 0x66 is transmitted sixth.
- Reset mid-frame: assert reset at cycle 35 of a frame with 2 words queued -> serial_out=1, tx_busy=0 and fifo_count=0 after the edge. No further frames are sent; the next push after deassertion transmits normally.
- WIDTH=5 and WIDTH=9 builds: push 0x15 and 0x1AB respectively -> the correct LSB-first bits appear and the frame lengths are 70 and 110 cycles (PARITY=0, STOP_BITS=1, 10 cycles/bit).
